// File: rtl/uart_arb_pkg.sv
// Shared types for the quad UART transmit arbiter.
// Holds the lock FSM encoding and the default end-of-line byte.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO between the arbiter and UART send.
// Head reads as zero while empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_send_arb.sv
// Round-robin arbiter sharing UART send between the cores of a quad.
// A core holds the grant until it sends EOL_CHAR or goes idle too long.
module uart_send_arb
  import uart_arb_pkg::*;
#(
  parameter int         N_REQ        = 4,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] EOL_CHAR     = EOL_DEFAULT,
  parameter bit         LOCK_EN      = 1'b1,
  parameter int         LOCK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   core_req,
  input  logic [8*N_REQ-1:0] core_data,
  output logic [N_REQ-1:0]   core_ack,
  output logic               uart_send_req,
  output logic [7:0]         uart_send_data,
  input  logic               uart_send_ready,
  output logic               lock_active,
  output logic [2:0]         lock_owner
);

  localparam int          IW      = $clog2(N_REQ);
  localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);

  arb_state_t    state, state_nx;
  logic [IW-1:0] last_grant, last_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [15:0]   timer, timer_nx;
  logic [IW-1:0] sel, cand;
  logic          sel_vld;
  logic [7:0]    sel_byte;
  logic          acked;
  logic          full;
  logic          empty;
  int            idx;

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    if (state == LOCKED) begin
      sel     = owner;
      sel_vld = core_req[owner];
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        cand = IW'(idx);
        if (!sel_vld && core_req[cand]) begin
          sel_vld = 1'b1;
          sel     = cand;
        end
      end
    end
  end

  // A full FIFO stalls the grant even if UART pops on the same edge.
  always_comb begin
    sel_byte = '0;
    core_ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == sel) begin
        sel_byte    = core_data[8*i +: 8];
        core_ack[i] = sel_vld & ~full & ~rst;
      end
    end
  end

  assign acked = |core_ack;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_grant;
    timer_nx = timer;
    unique case (state)
      IDLE: begin
        if (acked) begin
          last_nx = sel;
          if (LOCK_EN && sel_byte != EOL_CHAR) begin
            state_nx = LOCKED;
            owner_nx = sel;
            timer_nx = '0;
          end
        end
      end
      LOCKED: begin
        if (acked) begin
          timer_nx = '0;
          if (sel_byte == EOL_CHAR) state_nx = IDLE;
        end else if (timer >= TO_LAST) begin
          state_nx = IDLE;
          last_nx  = owner;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IW'(N_REQ - 1);
      timer      <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_nx;
      timer      <= timer_nx;
    end
  end

  assign lock_active   = state == LOCKED;
  assign lock_owner    = 3'(owner);
  assign uart_send_req = ~empty;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (acked),
    .din  (sel_byte),
    .pop  (uart_send_req & uart_send_ready),
    .full (full),
    .empty(empty),
    .head (uart_send_data)
  );

endmodule

// File: tb/tb_uart_send_arb.sv
// Directed bench for uart_send_arb: one per-byte round-robin instance
// and one line-locking instance with a short idle timeout.
module tb_uart_send_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  rr_req, lk_req;
  logic [31:0] rr_data, lk_data;
  logic [3:0]  rr_ack, lk_ack;
  logic        rr_sreq, lk_sreq;
  logic [7:0]  rr_sdata, lk_sdata;
  logic        rr_ready, lk_ready;
  logic        rr_lact, lk_lact;
  logic [2:0]  rr_lown, lk_lown;

  int n_cmp = 0;
  int n_err = 0;
  int nack;
  logic [7:0] q_rr[$];
  logic [7:0] q_lk[$];

  uart_send_arb #(.LOCK_EN(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .core_req(rr_req), .core_data(rr_data), .core_ack(rr_ack),
    .uart_send_req(rr_sreq), .uart_send_data(rr_sdata),
    .uart_send_ready(rr_ready),
    .lock_active(rr_lact), .lock_owner(rr_lown)
  );

  uart_send_arb #(.LOCK_TIMEOUT(8)) u_lk (
    .clk(clk), .rst(rst),
    .core_req(lk_req), .core_data(lk_data), .core_ack(lk_ack),
    .uart_send_req(lk_sreq), .uart_send_data(lk_sdata),
    .uart_send_ready(lk_ready),
    .lock_active(lk_lact), .lock_owner(lk_lown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    lk_data[8*i +: 8] = b;
  endtask

  // Output-side scoreboard: every byte UART takes must be the next expected.
  always @(negedge clk) begin
    if (!rst) begin
      if (rr_sreq && rr_ready) begin
        if (q_rr.size() == 0) chk("rr_spurious", 32'(rr_sdata), 32'hFFFF_FFFF);
        else chk("rr_data", 32'(rr_sdata), 32'(q_rr.pop_front()));
      end
      if (lk_sreq && lk_ready) begin
        if (q_lk.size() == 0) chk("lk_spurious", 32'(lk_sdata), 32'hFFFF_FFFF);
        else chk("lk_data", 32'(lk_sdata), 32'(q_lk.pop_front()));
      end
    end
  end

  // Core 0 streams 50,51,52,53,54 then EOL, advancing after each accept.
  task automatic bp_cycle();
    logic hit;
    @(negedge clk);
    hit = lk_ack[0];
    if (hit) begin
      q_lk.push_back(lk_data[7:0]);
      nack++;
    end
    step();
    if (hit) begin
      set_byte(0, nack < 5 ? 8'h50 + 8'(nack) : 8'h0A);
      if (nack == 6) lk_req = 4'b0000;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rr_req = 4'b1111;
    rr_data = {8'h13, 8'h12, 8'h11, 8'h10};
    rr_ready = 1'b1;
    lk_req = 4'b1111;
    lk_data = '0;
    lk_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rr_ack", 32'(rr_ack), 32'h0);
    chk("rst_lk_ack", 32'(lk_ack), 32'h0);
    chk("rst_sreq", 32'({rr_sreq, lk_sreq}), 32'h0);
    chk("rst_sdata", 32'({rr_sdata, lk_sdata}), 32'h0);
    chk("rst_lock", 32'({lk_lact, lk_lown, rr_lact}), 32'h0);

    // Round-robin, no locking
    q_rr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    step();
    rst = 1'b0;
    lk_req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_ack", 32'(rr_ack), 32'(1 << (k % 4)));
      chk("rr_nolock", 32'(rr_lact), 32'h0);
      if (k > 0) chk("rr_latency", 32'(rr_sreq), 32'h1);
      step();
    end
    rr_req = 4'b0000;
    repeat (3) step();
    chk("rr_drained", 32'(q_rr.size()), 32'h0);

    // Line lock: core 2 sends "AB\n" while core 1 waits
    q_lk = '{8'h41, 8'h42, 8'h0A, 8'h31, 8'h0A};
    lk_req = 4'b0100;
    set_byte(2, 8'h41);
    @(negedge clk);
    chk("ll_ack_a", 32'(lk_ack), 32'h4);
    step();
    lk_req = 4'b0110;
    set_byte(2, 8'h42);
    set_byte(1, 8'h31);
    @(negedge clk);
    chk("ll_ack_b", 32'(lk_ack), 32'h4);
    chk("ll_lock1", 32'({lk_lact, lk_lown}), 32'hA);
    step();
    set_byte(2, 8'h0A);
    @(negedge clk);
    chk("ll_ack_eol", 32'(lk_ack), 32'h4);
    chk("ll_lock2", 32'({lk_lact, lk_lown}), 32'hA);
    step();
    lk_req = 4'b0010;
    @(negedge clk);
    chk("ll_release", 32'(lk_lact), 32'h0);
    chk("ll_ack_c1", 32'(lk_ack), 32'h2);
    step();
    set_byte(1, 8'h0A);
    @(negedge clk);
    chk("ll_lock_c1", 32'({lk_lact, lk_lown}), 32'h9);
    chk("ll_ack_c1_eol", 32'(lk_ack), 32'h2);
    step();
    lk_req = 4'b0000;
    repeat (4) step();
    chk("ll_drained", 32'(q_lk.size()), 32'h0);

    // Back-pressure: UART stalled for 10 cycles
    lk_ready = 1'b0;
    lk_req = 4'b0001;
    set_byte(0, 8'h50);
    nack = 0;
    for (int c = 0; c < 10; c++) bp_cycle();
    @(negedge clk);
    chk("bp_acks", 32'(nack), 32'h4);
    chk("bp_ack_low", 32'(lk_ack), 32'h0);
    chk("bp_sreq", 32'(lk_sreq), 32'h1);
    step();
    lk_ready = 1'b1;
    for (int c = 0; c < 20 && nack < 6; c++) bp_cycle();
    chk("bp_total", 32'(nack), 32'h6);
    repeat (8) step();
    chk("bp_drained", 32'(q_lk.size()), 32'h0);
    chk("bp_unlocked", 32'(lk_lact), 32'h0);

    // Timeout: core 3 sends 'x' then goes quiet
    lk_req = 4'b1001;
    set_byte(3, 8'h78);
    set_byte(0, 8'h30);
    @(negedge clk);
    chk("to_ack3", 32'(lk_ack), 32'h8);
    q_lk.push_back(8'h78);
    step();
    lk_req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_locked", 32'({lk_lact, lk_lown}), 32'hB);
      chk("to_hold", 32'(lk_ack), 32'h0);
      step();
    end
    @(negedge clk);
    chk("to_release", 32'(lk_lact), 32'h0);
    chk("to_ack0", 32'(lk_ack), 32'h1);
    q_lk.push_back(8'h30);
    step();
    set_byte(0, 8'h0A);
    @(negedge clk);
    chk("to_lock0", 32'({lk_lact, lk_lown}), 32'h8);
    chk("to_ack0_eol", 32'(lk_ack), 32'h1);
    q_lk.push_back(8'h0A);
    step();
    lk_req = 4'b0000;
    repeat (4) step();
    chk("to_drained", 32'(q_lk.size()), 32'h0);

    // Reset mid-line with three bytes queued
    lk_ready = 1'b0;
    lk_req = 4'b0010;
    for (int b = 0; b < 3; b++) begin
      set_byte(1, 8'h61 + 8'(b));
      @(negedge clk);
      chk("mr_ack", 32'(lk_ack), 32'h2);
      step();
    end
    lk_req = 4'b0000;
    @(negedge clk);
    chk("mr_pre_lock", 32'({lk_lact, lk_lown}), 32'h9);
    chk("mr_pre_sreq", 32'(lk_sreq), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_sreq", 32'(lk_sreq), 32'h0);
    chk("mr_lock", 32'(lk_lact), 32'h0);
    chk("mr_sdata", 32'(lk_sdata), 32'h0);
    step();
    rst = 1'b0;
    lk_ready = 1'b1;
    @(negedge clk);
    chk("mr_empty_after", 32'(lk_sreq), 32'h0);
    repeat (2) step();
    chk("mr_queue", 32'(q_lk.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
